// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronised sources, per-source edge/level PEND, MASK/MODE
// registers, fixed lowest-index priority and a non-nesting IDLE/REQ/SERVICE handshake.
module irq_ctrl #(
    parameter int unsigned NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [1:0]      addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic            ack,
    input  logic            eret,
    output logic            int_req,
    output logic [2:0]      int_id
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } state_e;

    localparam logic [1:0] AddrMask   = 2'd0;
    localparam logic [1:0] AddrPend   = 2'd1;
    localparam logic [1:0] AddrMode   = 2'd2;
    localparam logic [1:0] AddrStatus = 2'd3;

    state_e          state_q, state_d;
    logic [NSRC-1:0] src_q, src_qq;
    logic [NSRC-1:0] pend_edge_q, pend_edge_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] pend, elig, rise, clr;
    logic [2:0]      int_id_q, int_id_d;
    logic            int_req_q, int_req_d;
    logic [2:0]      win_id;
    logic            win_vld;

    // Only the low NSRC bits of write data carry register content.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:NSRC];

    // Level sources mirror the synchronised line; edge sources use the sticky bit.
    assign pend = (mode_q & pend_edge_q) | (~mode_q & src_qq);
    assign elig = pend & mask_q;
    assign rise = src_q & ~src_qq;

    // Register writes and sticky edge-pending update; a new edge beats a same-cycle clear.
    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        clr    = '0;
        if (we && addr == AddrMask) mask_d = wdata[NSRC-1:0];
        if (we && addr == AddrMode) mode_d = wdata[NSRC-1:0];
        if (we && addr == AddrPend) clr = wdata[NSRC-1:0];
        if (ack && state_q == StReq) clr = clr | (NSRC'(1) << int_id_q);
        pend_edge_d = mode_q & ((pend_edge_q & ~clr) | rise);
    end

    // Lowest eligible index wins.
    always_comb begin
        win_id  = '0;
        win_vld = |elig;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (elig[i]) win_id = 3'(i);
        end
    end

    // State register plus synchroniser, pending, configuration and output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            src_q       <= '0;
            src_qq      <= '0;
            pend_edge_q <= '0;
            mask_q      <= '0;
            mode_q      <= '0;
            int_id_q    <= '0;
            int_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src;
            src_qq      <= src_q;
            pend_edge_q <= pend_edge_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            int_id_q    <= int_id_d;
            int_req_q   <= int_req_d;
        end
    end

    // Next-state: REQ holds its source until taken (ack) or no longer eligible.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (win_vld) state_d = StReq;
            StReq: begin
                if (ack)                   state_d = StService;
                else if (!elig[int_id_q])  state_d = StIdle;
            end
            StService: if (eret) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Outputs: request tracks REQ, id latches only on IDLE->REQ.
    always_comb begin
        int_req_d = (state_d == StReq);
        int_id_d  = int_id_q;
        if (state_q == StIdle && state_d == StReq) int_id_d = win_id;
    end

    assign int_req = int_req_q;
    assign int_id  = int_id_q;

    // Register read mux, zero-extended.
    always_comb begin
        rdata = '0;
        unique case (addr)
            AddrMask:   rdata = {{(32 - NSRC){1'b0}}, mask_q};
            AddrPend:   rdata = {{(32 - NSRC){1'b0}}, pend};
            AddrMode:   rdata = {{(32 - NSRC){1'b0}}, mode_q};
            AddrStatus: rdata = {26'b0, state_q, 1'b0, int_id_q};
            default:    rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  src;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic        ack;
    logic        eret;
    logic [31:0] rdata;
    logic        int_req;
    logic [2:0]  int_id;

    irq_ctrl #(.NSRC(6)) dut (
        .clk     (clk),
        .reset   (reset),
        .src     (src),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .ack     (ack),
        .eret    (eret),
        .int_req (int_req),
        .int_id  (int_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;   // 0..3 register address, 4 int_req, 5 int_id
        logic [31:0] exp;
        int          at;
    } chk_t;

    typedef struct {
        logic [2:0] id;
        int         at;
    } irq_t;

    chk_t chk_q[$];
    irq_t irq_q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic req_prev = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: int_req rising is the DUT's output event; timed register/pin checks pop here too.
    always @(negedge clk) begin
        logic [31:0] act;
        irq_t        e;
        if (int_req && !req_prev) begin
            n_tests++;
            if (irq_q.size() == 0) begin
                n_fail++;
                $display("FAIL irq_unexpected: got int_id=%0d at cycle %0d, required no request",
                         int_id, cyc);
            end else begin
                e = irq_q.pop_front();
                if (int_id !== e.id || cyc != e.at) begin
                    n_fail++;
                    $display("FAIL irq_event: got id=%0d cycle=%0d, required id=%0d cycle=%0d",
                             int_id, cyc, e.id, e.at);
                end
            end
        end
        req_prev = int_req;
        for (int i = chk_q.size() - 1; i >= 0; i--) begin
            if (chk_q[i].at == cyc) begin
                if (chk_q[i].sel < 4)       act = rdata;
                else if (chk_q[i].sel == 4) act = {31'b0, int_req};
                else                        act = {29'b0, int_id};
                n_tests++;
                if (act !== chk_q[i].exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)",
                             chk_q[i].name, act, chk_q[i].exp, cyc);
                end
                chk_q.delete(i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    // Queue a check compared at the negedge of cycle cyc+dly; register reads use dly=0.
    task automatic chk(input string name, input int sel, input logic [31:0] exp, input int dly);
        chk_t c;
        if (sel < 4) addr = 2'(sel);
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        c.at   = cyc + dly;
        chk_q.push_back(c);
    endtask

    task automatic exp_irq(input logic [2:0] id, input int at);
        irq_t e;
        e.id = id;
        e.at = at;
        irq_q.push_back(e);
    endtask

    int k, m;

    initial begin
        reset = 1'b0; src = '0; addr = '0; we = 1'b0; wdata = '0; ack = 1'b0; eret = 1'b0;
        tick(); tick();
        chk("rst_status", 3, 32'h0, 0); chk("rst_int_req", 4, 32'h0, 0);
        tick();
        chk("rst_mask", 0, 32'h0, 0);
        tick();
        reset = 1'b1;
        tick();

        // Edge source 0: latency, pending, ack/eret handshake
        wr(2'd0, 32'hFFFF_FF01);
        wr(2'd2, 32'h1);
        chk("mask_upper_ignored", 0, 32'h01, 0);
        tick();
        k = cyc;
        src = 6'b000001;
        exp_irq(3'd0, k + 3);
        chk("lat_not_early", 4, 32'h0, 2);
        tick(); src = '0; tick(); tick();
        chk("e0_pend", 1, 32'h01, 0); chk("e0_id", 5, 32'h0, 0);
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk("ack_drops_req", 4, 32'h0, 0); chk("ack_clears_pend", 1, 32'h0, 0);
        tick();
        chk("status_service", 3, 32'h20, 0);
        tick();
        eret = 1'b1; tick(); eret = 1'b0;
        chk("status_idle", 3, 32'h00, 0);
        tick();

        // Simultaneous edges on 1 and 2: priority, then second request after eret
        wr(2'd0, 32'h7);
        wr(2'd2, 32'h7);
        k = cyc;
        src = 6'b000110;
        exp_irq(3'd1, k + 3);
        tick(); src = '0; tick(); tick();
        chk("both_pend", 1, 32'h06, 0);
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk("svc_pend", 1, 32'h04, 0); chk("no_nesting", 4, 32'h0, 0);
        tick();
        eret = 1'b1; tick(); eret = 1'b0;
        exp_irq(3'd2, cyc + 1);
        tick();
        chk("second_id", 5, 32'h2, 0);
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        chk("all_clear", 1, 32'h0, 0);
        tick();

        // Level source 1: held, write-immune PEND, drop before ack
        wr(2'd2, 32'h0);
        wr(2'd0, 32'h2);
        k = cyc;
        src = 6'b000010;
        exp_irq(3'd1, k + 3);
        tick(); tick(); tick();
        chk("lvl_req", 4, 32'h1, 0); chk("lvl_status", 3, 32'h11, 0);
        tick();
        wr(2'd1, 32'h3F);
        chk("lvl_pend_w1c_ignored", 1, 32'h02, 0);
        tick();
        m = cyc;
        src = '0;
        chk("lvl_still_req", 4, 32'h1, 2);
        chk("lvl_dropped", 4, 32'h0, 3);
        tick(); tick(); tick();
        chk("lvl_status_idle", 3, 32'h01, 0);
        tick();

        // Edge set colliding with W1C of the same bit: set wins
        wr(2'd2, 32'h7);
        wr(2'd0, 32'h0);
        src = 6'b000001;
        tick();
        src = '0;
        addr = 2'd1; wdata = 32'h1; we = 1'b1;
        tick();
        we = 1'b0;
        chk("set_beats_clr", 1, 32'h01, 0);
        tick();
        wr(2'd1, 32'h1);
        chk("w1c_clears", 1, 32'h0, 0);
        tick();

        // Hold latched id despite higher priority arrival; masking latched source drops REQ
        wr(2'd0, 32'h7);
        k = cyc;
        src = 6'b000100;
        exp_irq(3'd2, k + 3);
        tick(); src = '0; tick(); tick();
        src = 6'b000001;
        tick(); src = '0; tick(); tick();
        chk("held_id", 5, 32'h2, 0); chk("held_req", 4, 32'h1, 0);
        tick();
        chk("held_pend", 1, 32'h05, 0);
        tick();
        wr(2'd0, 32'h3);
        m = cyc;
        chk("masked_drop", 4, 32'h0, 1);
        exp_irq(3'd0, m + 2);
        tick(); tick();
        chk("reraise_id", 5, 32'h0, 0);
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;

        // Asynchronous reset while in SERVICE
        wr(2'd0, 32'h4);
        exp_irq(3'd2, cyc + 1);
        tick();
        ack = 1'b1; tick(); ack = 1'b0;
        chk("pre_rst_status", 3, 32'h22, 0);
        tick();
        #2;
        reset = 1'b0;
        chk("async_rst_req", 4, 32'h0, 0); chk("async_rst_status", 3, 32'h0, 0);
        tick();
        chk("async_rst_pend", 1, 32'h0, 0);
        tick();
        chk("async_rst_mask", 0, 32'h0, 0);
        tick();
        reset = 1'b1;
        repeat (4) tick();

        foreach (chk_q[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: never compared, required 0x%0h at cycle %0d",
                     chk_q[i].name, chk_q[i].exp, chk_q[i].at);
        end
        foreach (irq_q[i]) begin
            n_tests++;
            n_fail++;
            $display("FAIL irq_missing: got no request, required id=%0d at cycle %0d",
                     irq_q[i].id, irq_q[i].at);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
